// File: rtl/touch_pkg.sv
// -----------------------------------------------------------------------------
// touch_pkg
// Shared declarations for the PS/2 touch receive sequencer.
//   rd_state_t : states of the consumer read sequencer
//   ERR_W_DEF  : default width of the receive-error counter
//   TO_W_DEF   : default width of the inactivity counter
//   satInc     : saturating increment for a counter of a given width
// Optional feature macro used by the users of this package: TOUCH_TIMEOUT_EN
// -----------------------------------------------------------------------------
package touch_pkg;

  typedef enum logic [1:0] {
    R_IDLE  = 2'd0,
    R_POP   = 2'd1,
    R_WAIT  = 2'd2,
    R_VALID = 2'd3
  } rd_state_t;

  localparam int ERR_W_DEF = 8;
  localparam int TO_W_DEF  = 16;

  // Increment value, but stop at the all-ones pattern of a width-bit counter.
  // Works on a 32-bit container so any counter up to 32 bits can use it.
  function automatic logic [31:0] satInc(input logic [31:0] value, input int width);
    logic [31:0] maxVal;
    maxVal = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
    return (value >= maxVal) ? value : value + 32'd1;
  endfunction

endpackage

// File: rtl/touch_wdog.sv
// -----------------------------------------------------------------------------
// touch_wdog
// Inactivity counter for the touch receive path. Counts consecutive quiet
// cycles while running and reports when the limit has been reached.
// Ports:
//   clk_i      clock (divided PS/2-side clock)
//   reset_i    synchronous, active-high reset
//   run_i      counter runs while 1, is held at 0 while 0
//   kick_i     receiver activity; restarts the count from 0
//   expired_o  1 in any quiet running cycle once TO_CYC-1 quiet cycles preceded it
// Only instantiated when TOUCH_TIMEOUT_EN is defined.
// -----------------------------------------------------------------------------
module touch_wdog #(
  parameter int TO_CYC = 50000,
  parameter int TO_W   = 16
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic run_i,
  input  logic kick_i,
  output logic expired_o
);

  logic [TO_W-1:0] cnt_q;
  logic [TO_W-1:0] cnt_d;
  logic            atLimit;

  assign atLimit = (cnt_q == TO_W'(TO_CYC - 1));

  // Quiet-cycle count: restart on activity or when stopped, otherwise count
  // up and park at the limit so the expiry keeps being reported.
  always_comb begin
    cnt_d = cnt_q;
    if (!run_i || kick_i) begin
      cnt_d = '0;
    end else if (!atLimit) begin
      cnt_d = cnt_q + TO_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = run_i && !kick_i && atLimit;

endmodule

// File: rtl/touch_rx_sched.sv
// -----------------------------------------------------------------------------
// touch_rx_sched
// Sequencer between the PS/2 touch receiver, its byte FIFO and the consumer.
// Turns receiver done/error pulses into FIFO pushes, drops bytes when the FIFO
// is full, serves consumer reads with a pop/wait/valid sequence and keeps
// error/overflow/timeout status. Everything runs on the divided PS/2 clock.
// Ports:
//   clk, reset              clock, synchronous active-high reset
//   enable                  accept new bytes from the receiver
//   ps2_done, ps2_error     receiver byte-complete / byte-error pulses
//   fifo_full, fifo_empty   FIFO flags
//   rd_req                  consumer read request (level)
//   clr_status              clears overflow, err_cnt and timeout
//   fifo_wr, fifo_rd        FIFO push / pop strobes
//   data_valid              FIFO data_out holds the popped byte this cycle
//   avail                   registered !fifo_empty
//   overflow                sticky: a good byte was dropped
//   err_cnt                 saturating count of ps2_error pulses
//   timeout                 sticky inactivity flag
// Optional feature: TOUCH_TIMEOUT_EN adds the inactivity watchdog; without it
// timeout is tied low and TO_CYC/TO_W do not exist.
// -----------------------------------------------------------------------------
module touch_rx_sched
  import touch_pkg::*;
#(
  parameter int ERR_W       = ERR_W_DEF,
  parameter int FIFO_RD_LAT = 1
`ifdef TOUCH_TIMEOUT_EN
  ,
  parameter int TO_CYC      = 50000,
  parameter int TO_W        = TO_W_DEF
`endif
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             ps2_done,
  input  logic             ps2_error,
  input  logic             fifo_full,
  input  logic             fifo_empty,
  input  logic             rd_req,
  input  logic             clr_status,
  output logic             fifo_wr,
  output logic             fifo_rd,
  output logic             data_valid,
  output logic             avail,
  output logic             overflow,
  output logic [ERR_W-1:0] err_cnt,
  output logic             timeout
);

  logic             wrPend_q, wrPend_d;
  logic             overflow_q, overflow_d;
  logic [ERR_W-1:0] errCnt_q, errCnt_d;
  logic             avail_q;
  logic             goodDone;
  logic             ovSet;
  rd_state_t        state_q, state_d;
  logic [1:0]       waitCnt_q, waitCnt_d;

  assign goodDone = ps2_done && enable && !ps2_error;

  // Write path and status. A good byte becomes a push one cycle later. If the
  // FIFO has filled up in the meantime the push is suppressed and counted as
  // an overflow, so fifo_wr never fires into a full FIFO. A set event in the
  // same cycle as clr_status wins, leaving the flag or count at 1.
  always_comb begin
    wrPend_d   = goodDone && !fifo_full;
    ovSet      = (goodDone && fifo_full) || (wrPend_q && fifo_full);
    overflow_d = clr_status ? ovSet : (overflow_q || ovSet);
    errCnt_d   = errCnt_q;
    if (clr_status) begin
      errCnt_d = ps2_error ? ERR_W'(1) : '0;
    end else if (ps2_error) begin
      errCnt_d = ERR_W'(satInc(32'(errCnt_q), ERR_W));
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wrPend_q   <= 1'b0;
      overflow_q <= 1'b0;
      errCnt_q   <= '0;
      avail_q    <= 1'b0;
    end else begin
      wrPend_q   <= wrPend_d;
      overflow_q <= overflow_d;
      errCnt_q   <= errCnt_d;
      avail_q    <= !fifo_empty;
    end
  end

  assign fifo_wr  = wrPend_q && !fifo_full;
  assign overflow = overflow_q;
  assign err_cnt  = errCnt_q;
  assign avail    = avail_q;

  // Read sequencer state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= R_IDLE;
      waitCnt_q <= '0;
    end else begin
      state_q   <= state_d;
      waitCnt_q <= waitCnt_d;
    end
  end

  // Read sequencer: pop once, wait out the FIFO read latency, then flag the
  // data. Only this block pops, so a FIFO seen non-empty in R_IDLE is still
  // non-empty in R_POP. With a latency of 1 the wait state is skipped.
  always_comb begin
    state_d    = state_q;
    waitCnt_d  = waitCnt_q;
    fifo_rd    = 1'b0;
    data_valid = 1'b0;
    case (state_q)
      R_IDLE: begin
        if (rd_req && !fifo_empty) begin
          state_d = R_POP;
        end
      end
      R_POP: begin
        fifo_rd = 1'b1;
        if (FIFO_RD_LAT > 1) begin
          state_d   = R_WAIT;
          waitCnt_d = 2'(FIFO_RD_LAT - 2);
        end else begin
          state_d = R_VALID;
        end
      end
      R_WAIT: begin
        if (waitCnt_q == 2'd0) begin
          state_d = R_VALID;
        end else begin
          waitCnt_d = waitCnt_q - 2'd1;
        end
      end
      R_VALID: begin
        data_valid = 1'b1;
        state_d    = R_IDLE;
      end
      default: begin
        state_d = R_IDLE;
      end
    endcase
  end

`ifdef TOUCH_TIMEOUT_EN
  logic timeout_q, timeout_d;
  logic expired;

  touch_wdog #(
    .TO_CYC(TO_CYC),
    .TO_W  (TO_W)
  ) u_wdog (
    .clk_i    (clk),
    .reset_i  (reset),
    .run_i    (enable),
    .kick_i   (ps2_done || ps2_error),
    .expired_o(expired)
  );

  // Sticky timeout flag; expiry in the clearing cycle keeps it set.
  always_comb begin
    timeout_d = clr_status ? expired : (timeout_q || expired);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= timeout_d;
    end
  end

  assign timeout = timeout_q;
`else
  assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_touch_rx_sched.sv
// -----------------------------------------------------------------------------
// tb_touch_rx_sched
// Randomised bench for touch_rx_sched. A small FIFO occupancy model supplies
// the full/empty flags. A reference model turns each cycle's inputs into
// time-stamped expectations (pushes, pops, data_valid pulses and the status
// outputs) that a separate monitor compares against the DUT on the falling edge.
// -----------------------------------------------------------------------------
module tb_touch_rx_sched;

  localparam int LAT    = 2;
  localparam int ERR_W  = 2;
  localparam int DEPTH  = 4;
  localparam int NCYC   = 3200;
  localparam int DRAIN  = 20;
  localparam int ERRMAX = (1 << ERR_W) - 1;
`ifdef TOUCH_TIMEOUT_EN
  localparam int TO_CYC = 16;
  localparam int TO_W   = 8;
`endif

  logic             clk = 1'b0;
  logic             reset;
  logic             enable;
  logic             ps2_done;
  logic             ps2_error;
  logic             fifo_full;
  logic             fifo_empty;
  logic             rd_req;
  logic             clr_status;
  logic             fifo_wr;
  logic             fifo_rd;
  logic             data_valid;
  logic             avail;
  logic             overflow;
  logic [ERR_W-1:0] err_cnt;
  logic             timeout;

  typedef struct {
    int stamp;
    int err;
    bit ov;
    bit av;
    bit to;
  } statExp_t;

  int       wrQ[$];
  int       rdQ[$];
  int       dvQ[$];
  statExp_t statQ[$];

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int occ    = 0;

  int errM, quietM, readFreeAt;
  bit ovM, avM, toM, pendW;

  always #5 clk = ~clk;

  touch_rx_sched #(
    .ERR_W      (ERR_W),
    .FIFO_RD_LAT(LAT)
`ifdef TOUCH_TIMEOUT_EN
    ,
    .TO_CYC     (TO_CYC),
    .TO_W       (TO_W)
`endif
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .enable    (enable),
    .ps2_done  (ps2_done),
    .ps2_error (ps2_error),
    .fifo_full (fifo_full),
    .fifo_empty(fifo_empty),
    .rd_req    (rd_req),
    .clr_status(clr_status),
    .fifo_wr   (fifo_wr),
    .fifo_rd   (fifo_rd),
    .data_valid(data_valid),
    .avail     (avail),
    .overflow  (overflow),
    .err_cnt   (err_cnt),
    .timeout   (timeout)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  // Drive one cycle of inputs. Phases change the traffic mix: read-heavy,
  // read-light (fills the FIFO), mixed, and nearly silent (inactivity).
  task automatic applyStimulus(input int i);
    int phase;
    int rdPct;
    int donePct;
    int errPct;
    phase = (i / 400) % 4;
    rdPct   = (phase == 0) ? 80 : (phase == 1) ? 10 : 45;
    donePct = (phase == 3) ? 2 : 20;
    errPct  = (phase == 3) ? 1 : 10;
    fifo_full  = (occ >= DEPTH);
    fifo_empty = (occ == 0);
    if (i >= NCYC) begin
      reset      = 1'b0;
      enable     = 1'b1;
      ps2_done   = 1'b0;
      ps2_error  = 1'b0;
      rd_req     = 1'b0;
      clr_status = 1'b0;
    end else begin
      reset      = (i < 3) || ($urandom_range(0, 299) == 0);
      enable     = ($urandom_range(0, 9) != 0);
      ps2_done   = ($urandom_range(0, 99) < donePct);
      ps2_error  = ($urandom_range(0, 99) < errPct);
      rd_req     = ($urandom_range(0, 99) < rdPct);
      clr_status = ($urandom_range(0, 39) == 0);
    end
  endtask

  // Reference model: what the inputs of cycle t imply for later cycles.
  task automatic modelStep(input int t);
    bit       ovSet;
    bit       goodDone;
    bit       toSet;
    statExp_t s;
    // A byte accepted last cycle is pushed now unless the FIFO filled up.
    ovSet = 1'b0;
    if (pendW) begin
      if (!fifo_full) wrQ.push_back(t);
      else ovSet = 1'b1;
    end
    if (reset) begin
      while (rdQ.size() > 0 && rdQ[$] > t) void'(rdQ.pop_back());
      while (dvQ.size() > 0 && dvQ[$] > t) void'(dvQ.pop_back());
      errM = 0; ovM = 0; avM = 0; toM = 0;
      quietM = 0; pendW = 0; readFreeAt = t + 1;
    end else begin
      goodDone = ps2_done && enable && !ps2_error;
      if (goodDone && fifo_full) ovSet = 1'b1;
      pendW = goodDone && !fifo_full;
      if (clr_status) errM = ps2_error ? 1 : 0;
      else if (ps2_error) errM = (errM == ERRMAX) ? ERRMAX : errM + 1;
      ovM = clr_status ? ovSet : (ovM || ovSet);
      avM = !fifo_empty;
      if (t >= readFreeAt && rd_req && !fifo_empty) begin
        rdQ.push_back(t + 1);
        dvQ.push_back(t + 1 + LAT);
        readFreeAt = t + 2 + LAT;
      end
      toSet = 1'b0;
`ifdef TOUCH_TIMEOUT_EN
      if (!enable || ps2_done || ps2_error) quietM = 0;
      else if (quietM < TO_CYC) quietM++;
      toSet = (quietM >= TO_CYC);
`endif
      toM = clr_status ? toSet : (toM || toSet);
    end
    s.stamp = t + 1;
    s.err   = errM;
    s.ov    = ovM;
    s.av    = avM;
    s.to    = toM;
    statQ.push_back(s);
  endtask

  // Stimulus, FIFO occupancy and reference model, one pass per cycle.
  initial begin
    bit lastWr;
    bit lastRd;
    lastWr = 1'b0;
    lastRd = 1'b0;
    errM = 0; quietM = 0; readFreeAt = 0;
    ovM = 0; avM = 0; toM = 0; pendW = 0;
    for (int i = 0; i < NCYC + DRAIN; i++) begin
      if (i > 0) begin
        @(negedge clk);
        lastWr = fifo_wr;
        lastRd = fifo_rd;
        @(posedge clk);
        #1;
        occ = occ + int'(lastWr) - int'(lastRd);
        if (occ < 0) occ = 0;
        if (occ > DEPTH) occ = DEPTH;
      end
      cyc = i;
      applyStimulus(i);
      modelStep(i);
    end
    @(negedge clk);
    #1;
    checkOutput("pending_writes", wrQ.size(), 0);
    checkOutput("pending_pops", rdQ.size(), 0);
    checkOutput("pending_valids", dvQ.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Monitor: consume expectations stamped with the current cycle.
  initial begin
    forever begin
      @(negedge clk);
      if (cyc >= 1) begin
        bit expWr;
        bit expRd;
        bit expDv;
        expWr = 1'b0;
        expRd = 1'b0;
        expDv = 1'b0;
        while (wrQ.size() > 0 && wrQ[0] < cyc) void'(wrQ.pop_front());
        while (rdQ.size() > 0 && rdQ[0] < cyc) void'(rdQ.pop_front());
        while (dvQ.size() > 0 && dvQ[0] < cyc) void'(dvQ.pop_front());
        if (wrQ.size() > 0 && wrQ[0] == cyc) begin expWr = 1'b1; void'(wrQ.pop_front()); end
        if (rdQ.size() > 0 && rdQ[0] == cyc) begin expRd = 1'b1; void'(rdQ.pop_front()); end
        if (dvQ.size() > 0 && dvQ[0] == cyc) begin expDv = 1'b1; void'(dvQ.pop_front()); end
        checkOutput("fifo_wr", 32'(fifo_wr), 32'(expWr));
        checkOutput("fifo_rd", 32'(fifo_rd), 32'(expRd));
        checkOutput("data_valid", 32'(data_valid), 32'(expDv));
        while (statQ.size() > 0 && statQ[0].stamp < cyc) void'(statQ.pop_front());
        if (statQ.size() > 0 && statQ[0].stamp == cyc) begin
          statExp_t s;
          s = statQ.pop_front();
          checkOutput("err_cnt", 32'(err_cnt), 32'(s.err));
          checkOutput("overflow", 32'(overflow), 32'(s.ov));
          checkOutput("avail", 32'(avail), 32'(s.av));
          checkOutput("timeout", 32'(timeout), 32'(s.to));
        end
      end
    end
  end

endmodule
